// File: rtl/io_port_bank.sv
// Memory-mapped I/O bank: latched output ports, synchronised input ports, sticky
// per-input change flags (W1C) and a maskable, registered interrupt.
module io_port_bank #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       NUM_OUT     = 2,
  parameter int unsigned       NUM_IN      = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'hF0,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         cpuAddr,
  input  logic [DATA_W-1:0]         cpuWrData,
  input  logic                      cpuWrEn,
  output logic [DATA_W-1:0]         cpuRdData,
  output logic                      hit,
  input  logic [NUM_IN*DATA_W-1:0]  inPorts,
  output logic [NUM_OUT*DATA_W-1:0] outPorts,
  output logic                      irq
);

  localparam int unsigned WIN = NUM_OUT + NUM_IN + 2;
  localparam logic [ADDR_W-1:0] WinA = ADDR_W'(WIN);
  localparam logic [ADDR_W-1:0] ChgA = ADDR_W'(NUM_OUT + NUM_IN);
  localparam logic [ADDR_W-1:0] IenA = ADDR_W'(NUM_OUT + NUM_IN + 1);

  if (NUM_IN < 1 || NUM_IN > DATA_W) begin : gBadNumIn
    $error("io_port_bank: NUM_IN must be 1..DATA_W");
  end
  if (NUM_OUT < 1 || NUM_OUT > 8) begin : gBadNumOut
    $error("io_port_bank: NUM_OUT must be 1..8");
  end
  if (SYNC_STAGES < 2) begin : gBadSync
    $error("io_port_bank: SYNC_STAGES must be >= 2");
  end
  if (longint'(BASE_ADDR) + longint'(WIN) > (longint'(1) << ADDR_W)) begin : gBadWin
    $error("io_port_bank: register window exceeds the address space");
  end

  logic [ADDR_W-1:0] off;
  logic              wrHit;

  logic [SYNC_STAGES-1:0][NUM_IN*DATA_W-1:0] syncQ;
  logic [NUM_IN-1:0][DATA_W-1:0]             syncIn, prevIn;
  logic [NUM_OUT-1:0][DATA_W-1:0]            outQ, outD;
  logic [NUM_IN-1:0]                         chgQ, chgD, chgSet, chgClr, ienQ, ienD;
  logic                                      irqQ;

  assign off    = cpuAddr - BASE_ADDR;
  assign hit    = (cpuAddr >= BASE_ADDR) && (off < WinA);
  assign wrHit  = hit & cpuWrEn;
  assign syncIn = syncQ[SYNC_STAGES-1];

  always_comb begin
    outD   = outQ;
    ienD   = ienQ;
    chgClr = '0;
    chgSet = '0;
    if (wrHit) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (off == ADDR_W'(k)) outD[k] = cpuWrData;
      end
      if (off == ChgA) chgClr = cpuWrData[NUM_IN-1:0];
      if (off == IenA) ienD = cpuWrData[NUM_IN-1:0];
    end
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      chgSet[k] = |(syncIn[k] ^ prevIn[k]);
    end
    // A new change on the clearing edge survives the W1C.
    chgD = (chgQ & ~chgClr) | chgSet;
  end

  always_comb begin
    cpuRdData = '0;
    if (hit) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (off == ADDR_W'(k)) cpuRdData = outQ[k];
      end
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        if (off == ADDR_W'(NUM_OUT + k)) cpuRdData = syncIn[k];
      end
      if (off == ChgA) cpuRdData[NUM_IN-1:0] = chgQ;
      if (off == IenA) cpuRdData[NUM_IN-1:0] = ienQ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncQ  <= '0;
      prevIn <= '0;
      outQ   <= '0;
      chgQ   <= '0;
      ienQ   <= '0;
      irqQ   <= 1'b0;
    end else begin
      syncQ  <= {syncQ[SYNC_STAGES-2:0], inPorts};
      prevIn <= syncIn;
      outQ   <= outD;
      chgQ   <= chgD;
      ienQ   <= ienD;
      // Built from the registered flags, so irq trails CHG/IEN by one edge.
      irqQ   <= |(chgQ & ienQ);
    end
  end

  assign outPorts = outQ;
  assign irq      = irqQ;

endmodule

// File: tb/tb_io_port_bank.sv
// Bench for io_port_bank: queue-based reference model checked every cycle, plus
// directed vectors with hand-computed expectations.
module tb_io_port_bank;

  localparam int S = 2;

  logic        clk;
  logic        rst;
  logic [7:0]  cpuAddr;
  logic [7:0]  cpuWrData;
  logic        cpuWrEn;
  logic [7:0]  cpuRdData;
  logic        hit;
  logic [15:0] inPorts;
  logic [15:0] outPorts;
  logic        irq;

  int passed = 0;
  int total  = 0;

  io_port_bank dut (
    .clk      (clk),
    .rst      (rst),
    .cpuAddr  (cpuAddr),
    .cpuWrData(cpuWrData),
    .cpuWrEn  (cpuWrEn),
    .cpuRdData(cpuRdData),
    .hit      (hit),
    .inPorts  (inPorts),
    .outPorts (outPorts),
    .irq      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: pin history queue, hist[0] = pins at the latest edge.
  logic [7:0]  mOut[2];
  logic [1:0]  mChg, mIen;
  logic        mIrq;
  logic [15:0] hist[$];

  function automatic bit inWin(input logic [7:0] a);
    return (a >= 8'hF0) && (a < 8'hF6);
  endfunction

  function automatic logic [7:0] mRead(input logic [7:0] a);
    logic [15:0] syn;
    if (!inWin(a)) return 8'h00;
    syn = hist[S-1];
    case (a - 8'hF0)
      8'd0:    return mOut[0];
      8'd1:    return mOut[1];
      8'd2:    return syn[7:0];
      8'd3:    return syn[15:8];
      8'd4:    return {6'b0, mChg};
      default: return {6'b0, mIen};
    endcase
  endfunction

  initial begin
    logic [15:0] synOld, prvOld;
    logic [1:0]  setB, clrB, ienNew;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mOut[0] = 8'h00; mOut[1] = 8'h00;
        mChg = 2'b00; mIen = 2'b00; mIrq = 1'b0;
        hist = {};
        for (int i = 0; i <= S; i++) hist.push_back(16'h0000);
      end else begin
        synOld = hist[S-1];
        prvOld = hist[S];
        setB   = {synOld[15:8] != prvOld[15:8], synOld[7:0] != prvOld[7:0]};
        clrB   = 2'b00;
        ienNew = mIen;
        mIrq   = |(mChg & mIen);
        if (cpuWrEn && inWin(cpuAddr)) begin
          case (cpuAddr - 8'hF0)
            8'd0: mOut[0] = cpuWrData;
            8'd1: mOut[1] = cpuWrData;
            8'd4: clrB = cpuWrData[1:0];
            8'd5: ienNew = cpuWrData[1:0];
            default: ;
          endcase
        end
        mChg = (mChg & ~clrB) | setB;
        mIen = ienNew;
        hist.push_front(inPorts);
        void'(hist.pop_back());
      end
    end
  end

  // Continuous compare, away from both clock edges and from stimulus changes.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        check("rst_outPorts", outPorts, 16'h0000);
        check("rst_irq", irq, 1'b0);
      end else begin
        check("outPorts", outPorts, {mOut[1], mOut[0]});
        check("irq", irq, mIrq);
        check("hit", hit, inWin(cpuAddr));
        check("cpuRdData", cpuRdData, mRead(cpuAddr));
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cpuAddr = a; cpuWrData = d; cpuWrEn = 1'b1;
    @(negedge clk);
    cpuWrEn = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    cpuAddr = a;
    #1;
    d = cpuRdData;
  endtask

  logic [7:0] r;

  initial begin
    rst = 1'b0; cpuAddr = 8'h00; cpuWrData = 8'h00; cpuWrEn = 1'b0;
    inPorts = 16'($urandom);

    // 1. reset
    repeat (3) @(negedge clk);
    check("t1_outPorts_in_reset", outPorts, 16'h0000);
    check("t1_irq_in_reset", irq, 1'b0);
    inPorts = 16'h0000;
    #3 rst = 1'b1;
    repeat (4) @(negedge clk);
    rd(8'hF4, r); check("t1_chg_after_release", r, 8'h00);

    // 2. output latches
    wr(8'hF0, 8'hA5);
    check("t2_out0", outPorts, 16'h00A5);
    wr(8'hF1, 8'h3C);
    check("t2_out1", outPorts, 16'h3CA5);
    rd(8'hF0, r); check("t2_rd_out0", r, 8'hA5);
    rd(8'hF1, r); check("t2_rd_out1", r, 8'h3C);
    wr(8'hF2, 8'hFF);
    rd(8'hF2, r); check("t2_in_ro", r, 8'h00);
    check("t2_out_unchanged", outPorts, 16'h3CA5);

    // 3. input sync and change latency
    inPorts = 16'h0081;
    @(negedge clk);
    rd(8'hF2, r); check("t3_in_after1", r, 8'h00);
    @(negedge clk);
    rd(8'hF2, r); check("t3_in_after2", r, 8'h81);
    rd(8'hF4, r); check("t3_chg_after2", r, 8'h00);
    @(negedge clk);
    rd(8'hF4, r); check("t3_chg_after3", r, 8'h01);
    check("t3_irq_masked", irq, 1'b0);

    // 4. interrupt path
    wr(8'hF4, 8'h01);
    wr(8'hF5, 8'h03);
    rd(8'hF5, r); check("t4_ien", r, 8'h03);
    inPorts = 16'h0181;
    repeat (3) @(negedge clk);
    rd(8'hF4, r); check("t4_chg_edge3", r, 8'h02);
    check("t4_irq_edge3", irq, 1'b0);
    @(negedge clk);
    check("t4_irq_edge4", irq, 1'b1);
    wr(8'hF4, 8'h02);
    rd(8'hF4, r); check("t4_chg_cleared", r, 8'h00);
    check("t4_irq_still", irq, 1'b1);
    @(negedge clk);
    check("t4_irq_dropped", irq, 1'b0);

    // 5. set and clear on the same edge
    inPorts = 16'h0180;
    repeat (2) @(negedge clk);
    wr(8'hF4, 8'h01);
    rd(8'hF4, r); check("t5_set_wins", r, 8'h01);
    wr(8'hF4, 8'h01);
    rd(8'hF4, r); check("t5_clear", r, 8'h00);
    wr(8'hF5, 8'hFF);
    rd(8'hF5, r); check("t5_ien_upper_zero", r, 8'h03);

    // 6. out-of-window accesses, then reset mid-run
    cpuAddr = 8'hEF; #1;
    check("t6_hit_EF", hit, 1'b0);
    check("t6_rd_EF", cpuRdData, 8'h00);
    cpuAddr = 8'hF6; #1;
    check("t6_hit_F6", hit, 1'b0);
    check("t6_rd_F6", cpuRdData, 8'h00);
    wr(8'hEF, 8'h55);
    wr(8'hF6, 8'h66);
    check("t6_out_untouched", outPorts, 16'h3CA5);
    rd(8'hF5, r); check("t6_ien_untouched", r, 8'h03);
    inPorts = 16'h0080;
    repeat (4) @(negedge clk);
    check("t6_irq_before_rst", irq, 1'b1);
    #3 rst = 1'b0;
    #1;
    check("t6_async_out", outPorts, 16'h0000);
    check("t6_async_irq", irq, 1'b0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    repeat (5) @(negedge clk);
    rd(8'hF4, r); check("t6_chg_after_release", r, 8'h01);
    rd(8'hF2, r); check("t6_in_after_release", r, 8'h80);
    rd(8'hF5, r); check("t6_ien_reset", r, 8'h00);
    check("t6_irq_reset", irq, 1'b0);
    wr(8'hF4, 8'h01);
    repeat (3) @(negedge clk);
    rd(8'hF4, r); check("t6_no_refire", r, 8'h00);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
